irrigation_zone_scheduler: RTL and testbench
============================================

Name: irrigation_zone_scheduler

Overview:
Parametrised successor of the single-zone irrigation FSM. It serves ZONES independent beds from one shared pump and tank, and energises one zone at a time in round-robin order. Per run it selects drip, sprinkling or agrodefensive spraying, times the run with a prescaled tick, and enforces a pressure-recovery gap between zones. It sits between the soil/tank sensor conditioning logic and the valve drivers.

Parameters:
ZONES, 4, number of irrigation zones (2..8)
TIMER_W, 12, width of run/gap tick counters
TICK_DIV, 1000, clocks per timer tick (>=1)
SPRINKLE_TICKS, 300, sprinkling run length in ticks (>=1, < 2^TIMER_W)
DRIP_TICKS, 600, drip run length in ticks (>=1)
AGRO_TICKS, 120, agrodefensive run length in ticks (>=1)
GAP_TICKS, 10, idle ticks between consecutive runs (0 = no gap)

Ports:
clock  in  1  system clock, all logic on rising edge
resetN  in  1  synchronous active-low reset
soilDry  in  ZONES  per-zone "needs water" level
chooseIrrigation  in  ZONES  per-zone mode: 1 sprinkling, 0 drip
ad  in  ZONES  per-zone agrodefensive request level
waterLow  in  1  tank level low; inhibits and aborts irrigation
sprinkling  out  ZONES  sprinkler valve, one-hot or zero
agrodefensiveSprinkler  out  ZONES  agro dosing valve, one-hot or zero
drip  out  ZONES  drip valve, one-hot or zero
activeZone  out  $clog2(ZONES)  index of zone in RUN; 0 otherwise
busy  out  1  high in RUN or GAP
waterAlarm  out  1  registered copy of waterLow

Behaviour:
- Reset (resetN=0 at an edge): state IDLE. All valve outputs 0, activeZone=0, busy=0, waterAlarm=0. Round-robin pointer = ZONES-1, so zone 0 is checked first. agroDone cleared, timers and prescaler cleared. Reset overrides everything, including a run in progress.
- Eligible zone i: (soilDry[i] | (ad[i] & ~agroDone[i])) & ~waterLow.
- agroDone[i]: set when an agro run on zone i completes normally. Cleared whenever ad[i]=0. Each agro request is therefore served once per assertion.
- States: IDLE, RUN, GAP.
- IDLE: on an edge with any eligible zone, pick the first eligible zone searching upward from pointer+1 with wrap. Latch zone, latch mode, load the run counter, clear the prescaler, update the pointer, go to RUN. Valve outputs and busy are registered at that same edge, so they are visible the cycle after the request is first sampled.
- Mode latch, in priority order:
  - ad[i] & ~agroDone[i]: agro. agrodefensiveSprinkler[i]=1 and sprinkling[i]=1, AGRO_TICKS.
  - else chooseIrrigation[i]=1: sprinkling[i]=1, SPRINKLE_TICKS.
  - else: drip[i]=1, DRIP_TICKS.
- Latched mode and zone are fixed for the whole run. Changes on soilDry, chooseIrrigation or ad during the run are ignored (minimum dose guaranteed).
- RUN: the prescaler emits a tick every TICK_DIV clocks and the run counter decrements on each tick. A run lasts exactly duration*TICK_DIV clocks. On the final tick:
  - clear valves; set agroDone for an agro run;
  - GAP_TICKS>0: go to GAP, counter=GAP_TICKS, prescaler cleared;
  - GAP_TICKS=0: go to IDLE.
- GAP: all valves 0, busy=1, activeZone=0. Lasts GAP_TICKS*TICK_DIV clocks, then IDLE. Requests are evaluated only in IDLE.
- waterLow=1 in RUN: at the next edge, valves go to 0, the run counter is cleared, and the state goes to IDLE. No GAP, agroDone is not set, and the pointer keeps its updated value. IDLE grants nothing while waterLow=1.
- waterAlarm follows waterLow with 1-cycle latency in all states.
- Invariant: at most one zone has any valve high. drip is never high together with sprinkling or agro on the same zone.

Optional Feature:
RAIN_HOLD_EN: adds input port rainHold (1 bit). While rainHold=1 in RUN:
- valves are forced to 0;
- prescaler and run counter freeze;
- busy stays 1.
On release the run resumes with the remaining time. rainHold=1 also blocks grants in IDLE; GAP is unaffected. waterLow abort takes priority over hold. Without the macro the port is absent and runs are never paused.

Test Plan:
Common setup: ZONES=4, TICK_DIV=2, SPRINKLE_TICKS=3, DRIP_TICKS=5, AGRO_TICKS=2, GAP_TICKS=1.
1. Reset, then soilDry=4'b0100, chooseIrrigation=0 -> drip[2]=1 and activeZone=2 for exactly 10 clocks, then busy=1 with valves 0 for 2 clocks, then IDLE.
2. soilDry=4'b1011 held, all sprinkling -> zones served in order 0,1,3,0; each has sprinkling high for 6 clocks with a 2-clock gap between runs.
3. ad=4'b0010, soilDry=0 -> sprinkling[1] and agrodefensiveSprinkler[1] high for 4 clocks. With ad held, zone 1 is not regranted. After ad drops and rises again, zone 1 gets a second agro run.
4. waterLow=1 on the 3rd clock of a drip run on zone 0 -> drip[0]=0 and busy=0 after the next edge, waterAlarm=1. No grant occurs until waterLow=0.
5. Mid-run toggle of chooseIrrigation[0] and soilDry[0]->0 during a sprinkling run -> the run still lasts 6 clocks and drip[0] stays 0.
6. (RAIN_HOLD_EN) rainHold=1 for 7 clocks after clock 2 of a sprinkling run -> valve low during the hold. Total valve-high time is still 6 clocks; completion is delayed by 7.

Source files
------------

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation scheduler: one zone energised at a time from a shared pump; valves registered 1 clock after grant.
// No backpressure; waterLow aborts runs, and optional RAIN_HOLD_EN (port rainHold) pauses a run with its remaining time kept.
module irrigation_zone_scheduler #(
  parameter int ZONES          = 4,
  parameter int TIMER_W        = 12,
  parameter int TICK_DIV       = 1000,
  parameter int SPRINKLE_TICKS = 300,
  parameter int DRIP_TICKS     = 600,
  parameter int AGRO_TICKS     = 120,
  parameter int GAP_TICKS      = 10
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [ZONES-1:0]         soilDry,
  input  logic [ZONES-1:0]         chooseIrrigation,
  input  logic [ZONES-1:0]         ad,
  input  logic                     waterLow,
`ifdef RAIN_HOLD_EN
  input  logic                     rainHold,
`endif
  output logic [ZONES-1:0]         sprinkling,
  output logic [ZONES-1:0]         agrodefensiveSprinkler,
  output logic [ZONES-1:0]         drip,
  output logic [$clog2(ZONES)-1:0] activeZone,
  output logic                     busy,
  output logic                     waterAlarm
);

  localparam int ZW = $clog2(ZONES);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  typedef enum logic [1:0] {M_DRIP, M_SPRINK, M_AGRO} mode_t;

  state_t             state;
  mode_t              mode, pick_mode;
  logic [ZW-1:0]      zone, ptr, pick;
  logic [TIMER_W-1:0] cnt, pick_dur;
  logic [PW-1:0]      presc;
  logic [ZONES-1:0]   agro_done, elig, pick_oh, zone_oh;
  logic               found, tick, hold;

`ifdef RAIN_HOLD_EN
  assign hold = rainHold;
`else
  assign hold = 1'b0;
`endif

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign pick_oh = ZONES'(1) << pick;
  assign zone_oh = ZONES'(1) << zone;

  // First eligible zone strictly after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    elig  = (soilDry | (ad & ~agro_done)) & {ZONES{~waterLow}};
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= ZONES; k++) begin
      idx = (int'(ptr) + k) % ZONES;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = ZW'(idx);
      end
    end
    if (ad[pick] && !agro_done[pick]) begin
      pick_mode = M_AGRO;
      pick_dur  = TIMER_W'(AGRO_TICKS);
    end else if (chooseIrrigation[pick]) begin
      pick_mode = M_SPRINK;
      pick_dur  = TIMER_W'(SPRINKLE_TICKS);
    end else begin
      pick_mode = M_DRIP;
      pick_dur  = TIMER_W'(DRIP_TICKS);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state                  <= IDLE;
      mode                   <= M_DRIP;
      zone                   <= '0;
      ptr                    <= ZW'(ZONES - 1);
      cnt                    <= '0;
      presc                  <= '0;
      agro_done              <= '0;
      sprinkling             <= '0;
      agrodefensiveSprinkler <= '0;
      drip                   <= '0;
      activeZone             <= '0;
      busy                   <= 1'b0;
      waterAlarm             <= 1'b0;
    end else begin
      waterAlarm <= waterLow;
      agro_done  <= agro_done & ad;
      case (state)
        IDLE: begin
          if (found && !hold) begin
            state                  <= RUN;
            zone                   <= pick;
            mode                   <= pick_mode;
            ptr                    <= pick;
            cnt                    <= pick_dur;
            presc                  <= '0;
            busy                   <= 1'b1;
            activeZone             <= pick;
            sprinkling             <= (pick_mode != M_DRIP) ? pick_oh : '0;
            agrodefensiveSprinkler <= (pick_mode == M_AGRO) ? pick_oh : '0;
            drip                   <= (pick_mode == M_DRIP) ? pick_oh : '0;
          end
        end
        RUN: begin
          if (waterLow) begin
            state                  <= IDLE;
            cnt                    <= '0;
            presc                  <= '0;
            busy                   <= 1'b0;
            activeZone             <= '0;
            sprinkling             <= '0;
            agrodefensiveSprinkler <= '0;
            drip                   <= '0;
          end else if (hold) begin
            sprinkling             <= '0;
            agrodefensiveSprinkler <= '0;
            drip                   <= '0;
          end else if (tick && cnt == TIMER_W'(1)) begin
            sprinkling             <= '0;
            agrodefensiveSprinkler <= '0;
            drip                   <= '0;
            activeZone             <= '0;
            presc                  <= '0;
            if (mode == M_AGRO)
              agro_done <= (agro_done | zone_oh) & ad;
            if (GAP_TICKS > 0) begin
              state <= GAP;
              cnt   <= TIMER_W'(GAP_TICKS);
            end else begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end else begin
            // Re-driven every cycle so valves come back after a hold.
            sprinkling             <= (mode != M_DRIP) ? zone_oh : '0;
            agrodefensiveSprinkler <= (mode == M_AGRO) ? zone_oh : '0;
            drip                   <= (mode == M_DRIP) ? zone_oh : '0;
            if (tick) begin
              presc <= '0;
              cnt   <= cnt - TIMER_W'(1);
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            presc <= '0;
            if (cnt <= TIMER_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - TIMER_W'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler with ZONES=4, TICK_DIV=2, run lengths 3/5/2 ticks, gap 1 tick.
module tb_irrigation_zone_scheduler;

  logic       clock = 1'b0;
  logic       resetN;
  logic [3:0] soilDry, chooseIrrigation, ad;
  logic       waterLow;
`ifdef RAIN_HOLD_EN
  logic       rainHold;
`endif
  logic [3:0] sprinkling, agrodefensiveSprinkler, drip;
  logic [1:0] activeZone;
  logic       busy, waterAlarm;

  int checks = 0;
  int errors = 0;

  irrigation_zone_scheduler #(
    .ZONES(4), .TIMER_W(12), .TICK_DIV(2), .SPRINKLE_TICKS(3),
    .DRIP_TICKS(5), .AGRO_TICKS(2), .GAP_TICKS(1)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .soilDry(soilDry),
    .chooseIrrigation(chooseIrrigation),
    .ad(ad),
    .waterLow(waterLow),
`ifdef RAIN_HOLD_EN
    .rainHold(rainHold),
`endif
    .sprinkling(sprinkling),
    .agrodefensiveSprinkler(agrodefensiveSprinkler),
    .drip(drip),
    .activeZone(activeZone),
    .busy(busy),
    .waterAlarm(waterAlarm)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    soilDry = '0; chooseIrrigation = '0; ad = '0; waterLow = 1'b0;
`ifdef RAIN_HOLD_EN
    rainHold = 1'b0;
`endif
    step(); step();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    resetN = 1'b0; waterLow = 1'b1; soilDry = 4'b1111;
    step();
    checks++;
    if ({sprinkling, agrodefensiveSprinkler, drip} !== 12'h000) begin
      errors++; $display("FAIL reset_valves: got %h want 000", {sprinkling, agrodefensiveSprinkler, drip});
    end
    checks++;
    if ({activeZone, busy, waterAlarm} !== 4'b0000) begin
      errors++; $display("FAIL reset_status: got %b want 0000", {activeZone, busy, waterAlarm});
    end
    waterLow = 1'b0; soilDry = 4'b0001; resetN = 1'b1;
    step();
    checks++;
    if (drip !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_start_run: got drip=%b busy=%b want 0001/1", drip, busy);
    end
    resetN = 1'b0;
    step();
    checks++;
    if (drip !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_abort_run: got drip=%b busy=%b want 0000/0", drip, busy);
    end
  endtask

  task automatic test_drip();
    int n, g;
    do_reset();
    soilDry = 4'b0100;
    step();
    soilDry = 4'b0000;
    checks++;
    if (drip !== 4'b0100 || activeZone !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL drip_grant: got drip=%b zone=%0d busy=%b want 0100/2/1", drip, activeZone, busy);
    end
    n = 0;
    while (drip == 4'b0100 && activeZone == 2'd2 && n < 50) begin n++; step(); end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL drip_length: got %0d clocks want 10", n); end
    g = 0;
    while (busy && {sprinkling, agrodefensiveSprinkler, drip} == 12'h000 && activeZone == 2'd0 && g < 50) begin
      g++; step();
    end
    checks++;
    if (g !== 2) begin errors++; $display("FAIL drip_gap: got %0d clocks want 2", g); end
    step();
    checks++;
    if (busy !== 1'b0 || drip !== 4'b0000) begin
      errors++; $display("FAIL drip_idle: got busy=%b drip=%b want 0/0000", busy, drip);
    end
  endtask

  task automatic test_round_robin();
    int zl[4] = '{0, 1, 3, 0};
    int w, n, g;
    do_reset();
    soilDry = 4'b1011; chooseIrrigation = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (sprinkling == 4'b0000 && w < 20) begin w++; step(); end
      if (k == 3) soilDry = 4'b0000;
      checks++;
      if (w !== 1 || sprinkling !== (4'b0001 << zl[k]) || activeZone !== 2'(zl[k])) begin
        errors++; $display("FAIL rr_grant%0d: got wait=%0d spr=%b zone=%0d want 1/zone %0d", k, w, sprinkling, activeZone, zl[k]);
      end
      n = 0;
      while (sprinkling == (4'b0001 << zl[k]) && n < 50) begin n++; step(); end
      checks++;
      if (n !== 6) begin errors++; $display("FAIL rr_length%0d: got %0d want 6", k, n); end
      g = 0;
      while (busy && sprinkling == 4'b0000 && g < 20) begin g++; step(); end
      checks++;
      if (g !== 2) begin errors++; $display("FAIL rr_gap%0d: got %0d want 2", k, g); end
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_idle: got busy=%b want 0", busy); end
    chooseIrrigation = 4'b0000;
  endtask

  task automatic test_agro();
    int n, g;
    bit seen;
    do_reset();
    ad = 4'b0010;
    step();
    checks++;
    if (sprinkling !== 4'b0010 || agrodefensiveSprinkler !== 4'b0010 || drip !== 4'b0000) begin
      errors++; $display("FAIL agro_grant: got spr=%b agro=%b drip=%b want 0010/0010/0000", sprinkling, agrodefensiveSprinkler, drip);
    end
    n = 0;
    while (agrodefensiveSprinkler == 4'b0010 && sprinkling == 4'b0010 && n < 50) begin n++; step(); end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL agro_length: got %0d want 4", n); end
    g = 0;
    while (busy && g < 20) begin g++; step(); end
    checks++;
    if (g !== 2) begin errors++; $display("FAIL agro_gap: got %0d want 2", g); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (busy) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL agro_no_regrant: got busy seen=%b want 0", seen); end
    ad = 4'b0000;
    step();
    ad = 4'b0010;
    step();
    checks++;
    if (agrodefensiveSprinkler !== 4'b0010 || sprinkling !== 4'b0010) begin
      errors++; $display("FAIL agro_second: got agro=%b spr=%b want 0010/0010", agrodefensiveSprinkler, sprinkling);
    end
    n = 0;
    while (agrodefensiveSprinkler == 4'b0010 && n < 50) begin n++; step(); end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL agro_second_length: got %0d want 4", n); end
    ad = 4'b0000;
    n = 0;
    while (busy && n < 20) begin n++; step(); end
  endtask

  task automatic test_water_low();
    int n;
    bit seen;
    do_reset();
    soilDry = 4'b0001;
    step();
    step(); step();
    waterLow = 1'b1;
    step();
    checks++;
    if (drip !== 4'b0000 || busy !== 1'b0 || waterAlarm !== 1'b1) begin
      errors++; $display("FAIL wl_abort: got drip=%b busy=%b alarm=%b want 0000/0/1", drip, busy, waterAlarm);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); if (busy || drip != 4'b0000) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL wl_no_grant: got activity=%b want 0", seen); end
    waterLow = 1'b0;
    step();
    soilDry = 4'b0000;
    checks++;
    if (drip !== 4'b0001 || waterAlarm !== 1'b0 || activeZone !== 2'd0) begin
      errors++; $display("FAIL wl_resume: got drip=%b alarm=%b want 0001/0", drip, waterAlarm);
    end
    n = 0;
    while (drip == 4'b0001 && n < 50) begin n++; step(); end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL wl_full_run: got %0d want 10", n); end
    n = 0;
    while (busy && n < 20) begin n++; step(); end
  endtask

  task automatic test_midrun_change();
    int n;
    bit drip_seen;
    do_reset();
    soilDry = 4'b0001; chooseIrrigation = 4'b0001;
    step();
    soilDry = 4'b0000; chooseIrrigation = 4'b0000;
    n = 0; drip_seen = 1'b0;
    while (sprinkling == 4'b0001 && n < 50) begin
      if (drip != 4'b0000) drip_seen = 1'b1;
      n++;
      if (n == 3) chooseIrrigation = 4'b0001;
      if (n == 4) chooseIrrigation = 4'b0000;
      step();
    end
    checks++;
    if (n !== 6 || drip_seen !== 1'b0) begin
      errors++; $display("FAIL midrun: got len=%0d drip_seen=%b want 6/0", n, drip_seen);
    end
    n = 0;
    while (busy && n < 20) begin n++; step(); end
  endtask

`ifdef RAIN_HOLD_EN
  task automatic test_rain_hold();
    int n;
    bit bad;
    do_reset();
    soilDry = 4'b0001; chooseIrrigation = 4'b0001;
    step();
    soilDry = 4'b0000;
    bad = (sprinkling != 4'b0001);
    step(); if (sprinkling != 4'b0001) bad = 1'b1;
    step(); if (sprinkling != 4'b0001) bad = 1'b1;
    rainHold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (sprinkling != 4'b0000 || !busy) bad = 1'b1;
    end
    rainHold = 1'b0;
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL hold_valves: got bad=%b want 0", bad); end
    step();
    n = 0;
    while (sprinkling == 4'b0001 && n < 50) begin n++; step(); end
    checks++;
    if (n !== 3 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_remaining: got %0d busy=%b want 3/1", n, busy);
    end
    chooseIrrigation = 4'b0000;
    n = 0;
    while (busy && n < 20) begin n++; step(); end
  endtask
`endif

  initial begin
    test_reset();
    test_drip();
    test_round_robin();
    test_agro();
    test_water_low();
    test_midrun_change();
`ifdef RAIN_HOLD_EN
    test_rain_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
